dual_port_banked_arb_memory: RTL and testbench
==============================================

// Module: dual_port_banked_arb_memory
// PURPOSE
// Single-clock, two-port (A/B) banked SRAM with per-port req/gnt handshake and a registered read path.
// Two ports to different banks are served in parallel. Two ports to the same bank are arbitrated round-robin.
// Memory contents are zero-cleared after every reset by a bank-parallel init sweep.
// Sits between two independent masters (e.g. DMA + core) and the shared buffer store.
// PARAMETERS
// WIDTH       12  data word width in bits
// ADDR_TOTAL  10  total address width; top log2(NUM_BANK) bits select bank, rest = in-bank address
// NUM_BANK    4   number of banks; power of 2, >=2
// (localparams) BANK_BITS = $clog2(NUM_BANK); ADDR_PER_BANK = ADDR_TOTAL-BANK_BITS; DEPTH = 2**ADDR_PER_BANK
// PORTS
// i_clk        in   1           single clock, all logic rising-edge
// i_rst_n      in   1           asynchronous, active-low reset
// i_req_a      in   1           port A request; must stay high with stable we/addr/din until o_gnt_a
// i_we_a       in   1           port A: 1=write, 0=read
// i_addr_a     in   ADDR_TOTAL  port A address
// i_din_a      in   WIDTH       port A write data
// o_gnt_a      out  1           port A request accepted this cycle (combinational from req/state/prio)
// o_rvalid_a   out  1           port A read data valid on o_dout_a (one-cycle pulse per read)
// o_dout_a     out  WIDTH       port A read data; holds last value when o_rvalid_a=0
// i_req_b .. o_dout_b           identical set for port B
// o_init_done  out  1           1 once post-reset clear sweep has finished
// o_conflict   out  1           registered pulse, 1 cycle after any same-bank A/B conflict
// BEHAVIOUR
// - Reset (async assert): o_gnt_*=0, o_rvalid_*=0, o_dout_*=0, o_init_done=0, o_conflict=0, prio=A, FSM=INIT, init_cnt=0.
// - Memory array itself is not reset; it is cleared by the INIT sweep.
// - FSM INIT: each cycle write 0 to address init_cnt in ALL banks; init_cnt++.
// - INIT -> RUN on the cycle init_cnt==DEPTH-1 is written; o_init_done=1 from the next cycle.
// - Clear therefore takes DEPTH cycles. All grants are 0 in INIT; requests are held, not lost.
// - FSM RUN: stays in RUN until reset. No other transitions.
// - Bank decode: bank = addr[ADDR_TOTAL-1 -: BANK_BITS]; row = addr[ADDR_PER_BANK-1:0].
// - No conflict (one req, or banks differ): every requesting port is granted the same cycle.
// - Conflict (both req, same bank): only the port named by prio is granted.
// - After a conflict, prio flips to the losing port; the loser is then granted the next cycle (no starvation).
// - prio is unchanged in non-conflict cycles. The same-address case is a conflict too and is serialized, never merged.
// - Granted write: array updated at the grant edge. A read granted in any later cycle returns the new data.
// - Granted read: o_rvalid_x=1 and o_dout_x=mem data exactly 1 cycle after the grant cycle (latency L=1).
// - Back-to-back grants give a continuous rvalid stream, one per read, in grant order.
// - Writes produce no rvalid. o_conflict=1 in the cycle after each conflict cycle.
// - Reset mid-operation: in-flight reads are dropped (rvalid forced 0) and the FSM restarts INIT from row 0.
// CONFIGURATION
// - Macro MBANK_OUT_REG_EN
//   - Defined: adds one output register stage per port; read latency L=2; rvalid/dout move together.
//     Reset value of the extra stage is 0.
//   - Undefined: L=1 as above. Grant, arbitration and init timing are identical in both builds.
// TESTING (WIDTH=12, ADDR_TOTAL=10, NUM_BANK=4, DEPTH=256)
// - Reset, hold reqs high: o_gnt_*=0 for 256 cycles, o_init_done rises cycle 257.
//   Then a read of every address returns 12'h000.
// - A write 0x0A5 @0x005, next cycle A read @0x005 -> o_rvalid_a and o_dout_a=0x0A5 at grant+L.
// - A read @0x010 (bank0) and B read @0x110 (bank1) in the same cycle -> both gnt same cycle, both rvalid at +L.
//   o_conflict stays 0.
// - A @0x020 and B @0x030 (both bank0), prio=A -> gnt_a only, gnt_b next cycle, o_conflict pulses once.
//   Repeat the conflict -> B wins first.
// - Both write the same addr 0x3FF (A=0x111, B=0x222), prio=A -> final read returns 0x222.
// - Assert reset during a read burst -> rvalid drops immediately, o_init_done=0, sweep restarts.
//   Rerun all of the above with MBANK_OUT_REG_EN defined; expect L=2.

Source files
------------

// File: rtl/dual_port_banked_arb_memory_if.sv
// Request/response bundle for both ports of dual_port_banked_arb_memory.
// The master drives requests; the slave (the memory) drives grants and read data.
interface dual_port_banked_arb_memory_if #(
    parameter int WIDTH      = 12,
    parameter int ADDR_TOTAL = 10
);
    logic                  i_req_a;
    logic                  i_we_a;
    logic [ADDR_TOTAL-1:0] i_addr_a;
    logic [WIDTH-1:0]      i_din_a;
    logic                  o_gnt_a;
    logic                  o_rvalid_a;
    logic [WIDTH-1:0]      o_dout_a;

    logic                  i_req_b;
    logic                  i_we_b;
    logic [ADDR_TOTAL-1:0] i_addr_b;
    logic [WIDTH-1:0]      i_din_b;
    logic                  o_gnt_b;
    logic                  o_rvalid_b;
    logic [WIDTH-1:0]      o_dout_b;

    logic                  o_init_done;
    logic                  o_conflict;

    modport master (
        output i_req_a, i_we_a, i_addr_a, i_din_a,
        output i_req_b, i_we_b, i_addr_b, i_din_b,
        input  o_gnt_a, o_rvalid_a, o_dout_a,
        input  o_gnt_b, o_rvalid_b, o_dout_b,
        input  o_init_done, o_conflict
    );

    modport slave (
        input  i_req_a, i_we_a, i_addr_a, i_din_a,
        input  i_req_b, i_we_b, i_addr_b, i_din_b,
        output o_gnt_a, o_rvalid_a, o_dout_a,
        output o_gnt_b, o_rvalid_b, o_dout_b,
        output o_init_done, o_conflict
    );
endinterface

// File: rtl/dual_port_banked_arb_memory.sv
// Two-port banked SRAM: round-robin arbitration on same-bank collisions, zero-clear sweep after reset.
// Define MBANK_OUT_REG_EN to add an output register stage per port (read latency 2 instead of 1).
module dual_port_banked_arb_memory_bank #(
    parameter int WIDTH    = 12,
    parameter int ROW_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [ROW_BITS-1:0] i_row,
    input  logic [WIDTH-1:0]    i_wdata,
    output logic [WIDTH-1:0]    o_rdata
);
    logic [WIDTH-1:0] mem [2**ROW_BITS];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_row] <= i_wdata;
    end

    assign o_rdata = mem[i_row];
endmodule

module dual_port_banked_arb_memory #(
    parameter int WIDTH      = 12,
    parameter int ADDR_TOTAL = 10,
    parameter int NUM_BANK   = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    dual_port_banked_arb_memory_if.slave    bus
);
    localparam int BANK_BITS     = $clog2(NUM_BANK);
    localparam int ADDR_PER_BANK = ADDR_TOTAL - BANK_BITS;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_PER_BANK-1:0] init_cnt_q, init_cnt_d;
    logic                     prio_q, prio_d;        // 0: A wins next conflict, 1: B wins
    logic                     conflict_q, conflict_d;
    logic                     rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic [WIDTH-1:0]         dout_a_q, dout_a_d, dout_b_q, dout_b_d;

    logic [BANK_BITS-1:0]     bank_a, bank_b;
    logic [ADDR_PER_BANK-1:0] row_a, row_b;
    logic                     conflict, gnt_a, gnt_b;

    logic [NUM_BANK-1:0]                    bank_we;
    logic [NUM_BANK-1:0][ADDR_PER_BANK-1:0] bank_row;
    logic [NUM_BANK-1:0][WIDTH-1:0]         bank_wdata, bank_rdata;

    assign bank_a = bus.i_addr_a[ADDR_TOTAL-1 -: BANK_BITS];
    assign bank_b = bus.i_addr_b[ADDR_TOTAL-1 -: BANK_BITS];
    assign row_a  = bus.i_addr_a[ADDR_PER_BANK-1:0];
    assign row_b  = bus.i_addr_b[ADDR_PER_BANK-1:0];

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prio_d     = prio_q;
        conflict_d = 1'b0;
        conflict   = 1'b0;
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (&init_cnt_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                conflict   = bus.i_req_a && bus.i_req_b && (bank_a == bank_b);
                gnt_a      = bus.i_req_a && (!conflict || !prio_q);
                gnt_b      = bus.i_req_b && (!conflict ||  prio_q);
                // the loser of a conflict owns the next one
                if (conflict) prio_d = gnt_a;
                conflict_d = conflict;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Each bank sees at most one access per cycle: the sweep, or whichever port was granted it.
    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            bank_we[b]    = 1'b0;
            bank_row[b]   = row_a;
            bank_wdata[b] = '0;
            if (state_q == ST_INIT) begin
                bank_we[b]  = 1'b1;
                bank_row[b] = init_cnt_q;
            end else if (gnt_a && (bank_a == BANK_BITS'(b))) begin
                bank_we[b]    = bus.i_we_a;
                bank_row[b]   = row_a;
                bank_wdata[b] = bus.i_din_a;
            end else if (gnt_b && (bank_b == BANK_BITS'(b))) begin
                bank_we[b]    = bus.i_we_b;
                bank_row[b]   = row_b;
                bank_wdata[b] = bus.i_din_b;
            end
        end
    end

    for (genvar g = 0; g < NUM_BANK; g++) begin : g_bank
        dual_port_banked_arb_memory_bank #(
            .WIDTH    (WIDTH),
            .ROW_BITS (ADDR_PER_BANK)
        ) u_bank (
            .i_clk   (i_clk),
            .i_we    (bank_we[g]),
            .i_row   (bank_row[g]),
            .i_wdata (bank_wdata[g]),
            .o_rdata (bank_rdata[g])
        );
    end

    always_comb begin
        rvalid_a_d = gnt_a && !bus.i_we_a;
        rvalid_b_d = gnt_b && !bus.i_we_b;
        dout_a_d   = rvalid_a_d ? bank_rdata[bank_a] : dout_a_q;
        dout_b_d   = rvalid_b_d ? bank_rdata[bank_b] : dout_b_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            prio_q     <= 1'b0;
            conflict_q <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            dout_a_q   <= '0;
            dout_b_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prio_q     <= prio_d;
            conflict_q <= conflict_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            dout_a_q   <= dout_a_d;
            dout_b_q   <= dout_b_d;
        end
    end

`ifdef MBANK_OUT_REG_EN
    logic             out_rvalid_a_q, out_rvalid_a_d, out_rvalid_b_q, out_rvalid_b_d;
    logic [WIDTH-1:0] out_dout_a_q, out_dout_a_d, out_dout_b_q, out_dout_b_d;

    always_comb begin
        out_rvalid_a_d = rvalid_a_q;
        out_rvalid_b_d = rvalid_b_q;
        out_dout_a_d   = dout_a_q;
        out_dout_b_d   = dout_b_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_rvalid_a_q <= 1'b0;
            out_rvalid_b_q <= 1'b0;
            out_dout_a_q   <= '0;
            out_dout_b_q   <= '0;
        end else begin
            out_rvalid_a_q <= out_rvalid_a_d;
            out_rvalid_b_q <= out_rvalid_b_d;
            out_dout_a_q   <= out_dout_a_d;
            out_dout_b_q   <= out_dout_b_d;
        end
    end

    assign bus.o_rvalid_a = out_rvalid_a_q;
    assign bus.o_rvalid_b = out_rvalid_b_q;
    assign bus.o_dout_a   = out_dout_a_q;
    assign bus.o_dout_b   = out_dout_b_q;
`else
    assign bus.o_rvalid_a = rvalid_a_q;
    assign bus.o_rvalid_b = rvalid_b_q;
    assign bus.o_dout_a   = dout_a_q;
    assign bus.o_dout_b   = dout_b_q;
`endif

    assign bus.o_gnt_a     = gnt_a;
    assign bus.o_gnt_b     = gnt_b;
    assign bus.o_init_done = (state_q == ST_RUN);
    assign bus.o_conflict  = conflict_q;
endmodule

// File: tb/tb_dual_port_banked_arb_memory.sv
// Bench for dual_port_banked_arb_memory: flat-memory reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dual_port_banked_arb_memory;
    localparam int WIDTH = 12;
    localparam int AT    = 10;
    localparam int NB    = 4;
    localparam int BB    = 2;
    localparam int DEPTH = 256;
`ifdef MBANK_OUT_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   conf_seen = 0;

    dual_port_banked_arb_memory_if #(.WIDTH(WIDTH), .ADDR_TOTAL(AT)) bus();

    dual_port_banked_arb_memory #(.WIDTH(WIDTH), .ADDR_TOTAL(AT), .NUM_BANK(NB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chkv(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference model: flat memory, a priority flag and an L-deep read delay line per port.
    logic [WIDTH-1:0] mmem [1<<AT];
    int               init_left = DEPTH;
    bit               prio_b, m_conf;
    bit               pv_a [1:L];
    bit               pv_b [1:L];
    logic [WIDTH-1:0] pd_a [1:L];
    logic [WIDTH-1:0] pd_b [1:L];
    logic [WIDTH-1:0] md_a, md_b;

    always @(negedge clk) begin : cmp
        bit ea, eb, cf;
        if (bus.o_conflict === 1'b1) conf_seen++;
        if (!rst_n) begin
            chk1("rst_gnt_a", bus.o_gnt_a, 1'b0);
            chk1("rst_gnt_b", bus.o_gnt_b, 1'b0);
            chk1("rst_rvalid_a", bus.o_rvalid_a, 1'b0);
            chk1("rst_rvalid_b", bus.o_rvalid_b, 1'b0);
            chkv("rst_dout_a", 32'(bus.o_dout_a), 32'd0);
            chkv("rst_dout_b", 32'(bus.o_dout_b), 32'd0);
            chk1("rst_init_done", bus.o_init_done, 1'b0);
            chk1("rst_conflict", bus.o_conflict, 1'b0);
            init_left = DEPTH;
            prio_b = 0;
            m_conf = 0;
            md_a = '0;
            md_b = '0;
            for (int i = 1; i <= L; i++) begin
                pv_a[i] = 0; pv_b[i] = 0; pd_a[i] = '0; pd_b[i] = '0;
            end
            for (int i = 0; i < (1<<AT); i++) mmem[i] = '0;
        end else begin
            ea = 0; eb = 0; cf = 0;
            if (init_left == 0) begin
                cf = bus.i_req_a && bus.i_req_b &&
                     (bus.i_addr_a[AT-1 -: BB] == bus.i_addr_b[AT-1 -: BB]);
                ea = bus.i_req_a && (!cf || !prio_b);
                eb = bus.i_req_b && (!cf ||  prio_b);
            end
            if (pv_a[L]) md_a = pd_a[L];
            if (pv_b[L]) md_b = pd_b[L];
            chk1("gnt_a", bus.o_gnt_a, ea);
            chk1("gnt_b", bus.o_gnt_b, eb);
            chk1("init_done", bus.o_init_done, init_left == 0);
            chk1("conflict", bus.o_conflict, m_conf);
            chk1("rvalid_a", bus.o_rvalid_a, pv_a[L]);
            chk1("rvalid_b", bus.o_rvalid_b, pv_b[L]);
            chkv("dout_a", 32'(bus.o_dout_a), 32'(md_a));
            chkv("dout_b", 32'(bus.o_dout_b), 32'(md_b));
            for (int i = L; i > 1; i--) begin
                pv_a[i] = pv_a[i-1]; pd_a[i] = pd_a[i-1];
                pv_b[i] = pv_b[i-1]; pd_b[i] = pd_b[i-1];
            end
            pv_a[1] = ea && !bus.i_we_a;
            pd_a[1] = mmem[bus.i_addr_a];
            pv_b[1] = eb && !bus.i_we_b;
            pd_b[1] = mmem[bus.i_addr_b];
            if (ea && bus.i_we_a) mmem[bus.i_addr_a] = bus.i_din_a;
            if (eb && bus.i_we_b) mmem[bus.i_addr_b] = bus.i_din_b;
            if (cf) prio_b = ea;
            m_conf = cf;
            if (init_left > 0) init_left--;
        end
    end

    // Drive a request pair (called at posedge+1) and hold each until granted; returns grant cycle index.
    task automatic op2(input bit ra, input bit wa, input logic [AT-1:0] aa, input logic [WIDTH-1:0] da,
                       input bit rb, input bit wb, input logic [AT-1:0] ab, input logic [WIDTH-1:0] db,
                       output int ga, output int gb);
        bit pa, pb;
        int k;
        pa = ra; pb = rb; k = 0; ga = -1; gb = -1;
        bus.i_req_a = ra; bus.i_we_a = wa; bus.i_addr_a = aa; bus.i_din_a = da;
        bus.i_req_b = rb; bus.i_we_b = wb; bus.i_addr_b = ab; bus.i_din_b = db;
        while ((pa || pb) && k < 600) begin
            @(negedge clk);
            k++;
            if (pa && bus.o_gnt_a) begin pa = 0; ga = k; end
            if (pb && bus.o_gnt_b) begin pb = 0; gb = k; end
            @(posedge clk); #1;
            if (!pa) bus.i_req_a = 1'b0;
            if (!pb) bus.i_req_b = 1'b0;
        end
        if (pa || pb) begin
            chk1("op_timeout", 1'b1, 1'b0);
            bus.i_req_a = 1'b0;
            bus.i_req_b = 1'b0;
        end
    endtask

    // Wait for port A (and optionally B) read data; checks latency from grant and value.
    task automatic expect_rd(input string name, input bit use_b,
                             input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(use_b ? bus.o_rvalid_b : bus.o_rvalid_a) && k < 8);
        chkv({name, "_lat"}, k, L);
        if (use_b) chkv({name, "_b"}, 32'(bus.o_dout_b), 32'(eb));
        else       chkv({name, "_a"}, 32'(bus.o_dout_a), 32'(ea));
        @(posedge clk); #1;
    endtask

    task automatic reset_and_init;
        int k;
        k = 0;
        rst_n = 1'b0;
        bus.i_req_a = 1'b0;
        bus.i_req_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.i_req_a = 1'b1; bus.i_we_a = 1'b0; bus.i_addr_a = 10'h000; bus.i_din_a = '0;
        bus.i_req_b = 1'b1; bus.i_we_b = 1'b0; bus.i_addr_b = 10'h100; bus.i_din_b = '0;
        while (!bus.o_init_done && k < 400) begin
            @(negedge clk);
            k++;
        end
        chkv("init_cycles", k, 257);
        chk1("first_run_gnt_a", bus.o_gnt_a, 1'b1);
        chk1("first_run_gnt_b", bus.o_gnt_b, 1'b1);
        @(posedge clk); #1;
        bus.i_req_a = 1'b0;
        bus.i_req_b = 1'b0;
    endtask

    initial begin
        int ga, gb, c0;
        bus.i_req_a = 1'b0; bus.i_we_a = 1'b0; bus.i_addr_a = '0; bus.i_din_a = '0;
        bus.i_req_b = 1'b0; bus.i_we_b = 1'b0; bus.i_addr_b = '0; bus.i_din_b = '0;
        #1 rst_n = 1'b0;
        #2;
        chk1("t0_init_done", bus.o_init_done, 1'b0);
        chk1("t0_rvalid_a", bus.o_rvalid_a, 1'b0);
        @(posedge clk); #1;
        reset_and_init();

        // whole array reads back zero; A covers banks 0-1, B covers banks 2-3
        for (int i = 0; i < 512; i++)
            op2(1, 0, 10'(i), '0, 1, 0, 10'(512 + i), '0, ga, gb);
        repeat (L + 1) @(negedge clk);
        @(posedge clk); #1;

        op2(1, 1, 10'h005, 12'h0A5, 0, 0, '0, '0, ga, gb);
        op2(1, 0, 10'h005, '0, 0, 0, '0, '0, ga, gb);
        chkv("rd_after_wr_gnt", ga, 1);
        expect_rd("rd_after_wr", 0, 12'h0A5, '0);

        c0 = conf_seen;
        op2(1, 1, 10'h010, 12'h123, 1, 1, 10'h110, 12'h456, ga, gb);
        chkv("diffbank_wr_same_cycle", ga, gb);
        op2(1, 0, 10'h010, '0, 1, 0, 10'h110, '0, ga, gb);
        chkv("diffbank_rd_gnt_a", ga, 1);
        chkv("diffbank_rd_gnt_b", gb, 1);
        expect_rd("diffbank_a", 0, 12'h123, '0);
        chkv("diffbank_dout_b", 32'(bus.o_dout_b), 32'h456);
        repeat (2) @(negedge clk);
        chkv("diffbank_no_conflict", conf_seen, c0);
        @(posedge clk); #1;

        op2(1, 0, 10'h020, '0, 1, 0, 10'h030, '0, ga, gb);
        chkv("conf1_a_first", ga, 1);
        chkv("conf1_b_next", gb, 2);
        repeat (3) @(negedge clk);
        chkv("conf1_pulse_once", conf_seen, c0 + 1);
        @(posedge clk); #1;
        op2(1, 0, 10'h020, '0, 1, 0, 10'h030, '0, ga, gb);
        chkv("conf2_b_first", gb, 1);
        chkv("conf2_a_next", ga, 2);
        repeat (3) @(negedge clk);
        chkv("conf2_pulse_once", conf_seen, c0 + 2);
        @(posedge clk); #1;

        op2(1, 1, 10'h3FF, 12'h111, 1, 1, 10'h3FF, 12'h222, ga, gb);
        chkv("sameaddr_a_first", ga, 1);
        chkv("sameaddr_b_second", gb, 2);
        op2(0, 0, '0, '0, 1, 0, 10'h3FF, '0, ga, gb);
        expect_rd("sameaddr_final", 1, '0, 12'h222);

        for (int i = 0; i < 4; i++)
            op2(1, 0, 10'h005, '0, 0, 0, '0, '0, ga, gb);
        chk1("burst_rvalid_live", bus.o_rvalid_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("burst_rst_rvalid_drop", bus.o_rvalid_a, 1'b0);
        chkv("burst_rst_dout", 32'(bus.o_dout_a), 32'd0);
        chk1("burst_rst_init_done", bus.o_init_done, 1'b0);
        @(posedge clk); #1;
        reset_and_init();

        op2(1, 0, 10'h005, '0, 1, 0, 10'h3FF, '0, ga, gb);
        expect_rd("cleared_5", 0, 12'h000, '0);
        chkv("cleared_3ff", 32'(bus.o_dout_b), 32'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
